// File: rtl/ysyx_041461_stage_reg_if.sv
// Handshake bundle for one pipeline boundary: upstream offer/accept on the
// in_* side, downstream present/consume on the out_* side.
interface ysyx_041461_stage_reg_if #(
    parameter int unsigned WIDTH = 32'd64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    // Surrounding pipeline: drives the offer and the downstream ready.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    // Stage register itself.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/ysyx_041461_stage_reg.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid
// buffer. in_ready, out_valid and out_data all come straight from flops, so
// there is no combinational path from out_ready back to in_ready. The skid
// entry absorbs the one offer that can slip in while in_ready is still high
// for the cycle after downstream stalls.
module ysyx_041461_stage_reg #(
    parameter int unsigned      WIDTH       = 32'd64,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    ysyx_041461_stage_reg_if.slave       bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    state_e           state_r;
    logic             out_valid_r;
    logic             in_ready_r;
    logic [WIDTH-1:0] out_data_r;
    logic [WIDTH-1:0] skid_data_r;

    logic             accept_s;
    logic             consume_s;

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;

    // Handshake qualifiers for the current cycle.
    always_comb begin
        accept_s  = 1'b0;
        consume_s = 1'b0;
        if (bus.in_valid && in_ready_r) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if (out_valid_r && bus.out_ready) begin
            consume_s = 1'b1;
        end else begin
            consume_s = 1'b0;
        end
    end

    // Occupancy FSM with registered handshake outputs and data movement.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            out_data_r  <= RESET_VALUE;
            skid_data_r <= RESET_VALUE;
        end else if (flush) begin
            // Squash occupancy only; data registers keep their last contents.
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        out_data_r  <= bus.in_data;
                        state_r     <= ST_FULL;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (accept_s && consume_s) begin
                        out_data_r  <= bus.in_data;
                        state_r     <= ST_FULL;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b1;
                    end else if (accept_s) begin
                        // Downstream stalled while we were still ready: park it.
                        skid_data_r <= bus.in_data;
                        state_r     <= ST_SKID;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b0;
                    end else if (consume_s) begin
                        // out_data keeps the stale value; it is marked invalid.
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r     <= ST_FULL;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b1;
                    end
                end
                ST_SKID: begin
                    if (consume_s) begin
                        out_data_r  <= skid_data_r;
                        state_r     <= ST_FULL;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r     <= ST_SKID;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/ysyx_041461_stage_reg.md
# ysyx_041461_stage_reg

Parametrised pipeline stage register with a valid/ready handshake and a one-entry skid buffer. It is the successor to the fixed-field per-stage registers driven by a global enable. Each pipeline boundary (IF/ID, ID/EXE, EXE/MEM, MEM/WB) instantiates one copy with its bundle packed into `in_data`. Backpressure is registered, so `in_ready` has no combinational path from `out_ready`. Flush squashes in-flight entries without resetting the datapath.

## Interface
- `WIDTH`, default 64: bit width of the packed stage bundle.
- `RESET_VALUE`, default `{WIDTH{1'b0}}`: value loaded into the output and skid data registers on reset.
- `clk` input 1: the only clock; every flop updates on its rising edge.
- `rst` input 1: synchronous, active-high reset. Sampled on the rising edge of `clk`.
- `flush` input 1: synchronous squash. Drops every held entry and any entry offered in the same cycle.
- `in_valid` input 1: the upstream stage offers `in_data`.
- `in_ready` output 1: this stage accepts an offer this cycle. Driven straight from a flop.
- `in_data` input WIDTH: upstream bundle.
- `out_valid` output 1: `out_data` holds a live entry. Driven straight from a flop.
- `out_ready` input 1: the downstream stage consumes `out_data` this cycle.
- `out_data` output WIDTH: current head entry. Driven straight from a flop.

## Operation
- Definitions:
  - Accept = `in_valid & in_ready`.
  - Consume = `out_valid & out_ready`.
- Internal storage: output register `out_data` plus skid register `skid_data`/`skid_valid`.
- States:
  - EMPTY: `out_valid`=0, `skid_valid`=0.
  - FULL: `out_valid`=1, `skid_valid`=0.
  - SKID: `out_valid`=1, `skid_valid`=1.
- `in_ready` = 1 in EMPTY and FULL, 0 in SKID. It is registered as `!skid_valid` of the next state.
- Priority: `rst` > `flush` > handshake.
- `rst`:
  - Next state is EMPTY.
  - `out_valid`=0 and `in_ready`=1.
  - `out_data` and `skid_data` take `RESET_VALUE`.
- `flush` (rst low):
  - Next state is EMPTY, `in_ready`=1.
  - `out_data` and `skid_data` keep their values.
  - An accept in the flush cycle is discarded.
  - A consume in the flush cycle still counts downstream; the block takes no extra action for it.
- EMPTY:
  - With accept: `out_data` <= `in_data`, go to FULL.
  - Otherwise stay; `out_data` holds.
- FULL:
  - Accept and consume: `out_data` <= `in_data`, stay FULL.
  - Accept, no consume: `skid_data` <= `in_data`, go to SKID.
  - Consume, no accept: go to EMPTY; `out_data` holds its stale value.
  - Neither: hold.
- SKID:
  - No accept is possible.
  - Consume: `out_data` <= `skid_data`, go to FULL.
  - Otherwise hold everything.
- While `out_valid`=0, `out_data` is don't-care to consumers and must not be interpreted. It is deterministic: the last value loaded, or `RESET_VALUE`.
- Ordering is strictly FIFO; no entry is lost or duplicated except through `flush` or `rst`.
- `in_valid` must not depend combinationally on `in_ready` upstream. The converse holds by construction.

## Timing
- Latency: an accept at edge N makes the entry visible on `out_data` with `out_valid`=1 after edge N. The consumer sees it in cycle N+1.
- Throughput: one entry per cycle while `out_ready` stays high.
- Backpressure delay:
  - `out_ready` dropping while FULL with an accept: the entry goes into the skid register, and `in_ready` drops after that edge. This is one cycle late, and the skid entry absorbs it.
  - SKID with consume: `in_ready` rises after the same edge. The upstream stage therefore sees one bubble cycle of `in_ready`=0.
- Reset mid-operation: all held entries vanish at the reset edge. `in_ready`=1 from the next cycle.
- `flush` and `rst` asserted together behave as `rst`.

## Test plan
- Reset values (`WIDTH`=8, `RESET_VALUE`=8'h5A):
  - Stimulus: assert `rst` for 2 cycles with `in_valid`=1, `in_data`=8'hFF.
  - Required: `out_valid`=0, `in_ready`=1, `out_data`=8'h5A; no entry accepted.
- Streaming:
  - Stimulus: `out_ready`=1; offer 8'h01, 8'h02, 8'h03 on consecutive cycles.
  - Required: `out_data` shows 01, 02, 03 one cycle after each accept, with `out_valid` held at 1 across those cycles. `in_ready` stays 1 throughout.
- Skid capture and drain:
  - Stimulus: in FULL holding 8'h10, set `out_ready`=0 while offering 8'h11; then `out_ready`=1.
  - Required: state goes to SKID and `in_ready`=0 the next cycle. After the first consume, `out_data`=8'h11. `in_ready`=1 again one cycle after the drain.
- Long stall:
  - Stimulus: in SKID, keep `out_ready`=0 for 5 cycles while `in_valid`=1 with 8'h20.
  - Required: `out_data` stays constant, `in_ready` stays 0, and 8'h20 is never accepted until `in_ready` returns.
- Flush:
  - Stimulus: in SKID holding 8'h30/8'h31, assert `flush` together with `in_valid`=1, `in_data`=8'h32.
  - Required: next cycle `out_valid`=0 and `in_ready`=1; 8'h32 never appears at the output. `out_data` keeps 8'h30 but is invalid.
- Reset mid-stream:
  - Stimulus: assert `rst` while FULL, with a simultaneous accept and `flush`.
  - Required: EMPTY, `out_data`=`RESET_VALUE`; the following accept appears after exactly one cycle.
